float_div_arb: RTL and testbench

Round-robin arbiter and sequencer that lets up to NREQ requesters share one pipelined, non-blocking `float_div_nb` divider. In the JPEG encoder, the Y/Cb/Cr quantisation lanes send IEEE-754 single-precision divide requests here. The block accepts at most one request per cycle. It tags each issued operation, tracks the tag through a shift pipeline matched to the divider latency, and returns each result to the requester that issued it. It also reports occupancy, idle state and a tag/valid misalignment error.

---
 rtl/float_div_arb_pkg.sv | 18 +
 rtl/float_div_arb_if.sv | 23 ++
 rtl/float_div_arb_rr_arbiter.sv | 55 +++++
 rtl/float_div_arb.sv | 112 +++++++++++
 tb/tb_float_div_arb.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_div_arb_pkg.sv
// rtl/float_div_arb_pkg.sv - shared widths, defaults and tag types for the divider arbiter
package float_div_arb_pkg;

    localparam int FLT_W       = 32;
    localparam int DEF_NREQ    = 3;
    localparam int DEF_LATENCY = 27;
    localparam int MAX_NREQ    = 8;
    localparam int TAG_W       = $clog2(MAX_NREQ);

    // Sized for the largest supported requester count so NREQ=1 never yields a zero-width tag
    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_stage_t;

endpackage

// File: rtl/float_div_arb_if.sv
// rtl/float_div_arb_if.sv - requester-side request/response bundle of the divider arbiter
interface float_div_arb_if
    import float_div_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*FLT_W-1:0] req_din1;
    logic [NREQ*FLT_W-1:0] req_din2;
    logic [NREQ-1:0]       rsp_valid;
    logic [FLT_W-1:0]      rsp_dout;

    modport master (
        output req_valid, req_din1, req_din2,
        input  req_ready, rsp_valid, rsp_dout
    );

    modport slave (
        input  req_valid, req_din1, req_din2,
        output req_ready, rsp_valid, rsp_dout
    );
endinterface

// File: rtl/float_div_arb_rr_arbiter.sv
// rtl/float_div_arb_rr_arbiter.sv - round-robin one-hot grant with rotating priority pointer
module rr_arbiter
    import float_div_arb_pkg::*;
#(
    parameter int N = DEF_NREQ
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant,
    output tag_t         grant_idx
);

    tag_t ptr;
    tag_t idx_hi;
    tag_t idx_lo;
    logic hit_hi;
    logic hit_lo;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall
    always_comb begin
        idx_hi    = '0;
        idx_lo    = '0;
        hit_hi    = 1'b0;
        hit_lo    = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i]) begin
                idx_lo = tag_t'(i);
                hit_lo = 1'b1;
                if (i >= int'(ptr)) begin
                    idx_hi = tag_t'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        if (en && !rst && hit_lo) begin
            grant_idx = hit_hi ? idx_hi : idx_lo;
            for (int i = 0; i < N; i++) begin
                grant[i] = (grant_idx == tag_t'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == tag_t'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/float_div_arb.sv
// rtl/float_div_arb.sv - shares one pipelined divider among NREQ requesters with tag-routed results
module float_div_arb
    import float_div_arb_pkg::*;
#(
    parameter int  NREQ    = DEF_NREQ,
    parameter int  LATENCY = DEF_LATENCY,
    localparam int IW      = $clog2(LATENCY + 2) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    float_div_arb_if.slave    req_bus,
    output logic              div_nrst,
    output logic [FLT_W-1:0]  div_din1,
    output logic [FLT_W-1:0]  div_din2,
    output logic              div_din_valid,
    input  logic [FLT_W-1:0]  div_dout,
    input  logic              div_dout_valid,
    output logic [IW-1:0]     inflight,
    output logic              idle,
    output logic              err
);

    logic [NREQ-1:0]  grant;
    tag_t             grant_idx;
    logic             accept;
    logic             rsp_fire;
    logic [FLT_W-1:0] din1_sel;
    logic [FLT_W-1:0] din2_sel;
    tag_t             issue_tag;
    tag_stage_t       tag_pipe [LATENCY];
    tag_stage_t       tag_out;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid     (req_bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_bus.req_ready = grant;
    assign accept            = |grant;
    assign div_nrst          = ~rst;
    assign idle              = (inflight == '0);
    assign rsp_fire          = div_dout_valid & tag_out.valid;

    always_comb begin
        din1_sel = '0;
        din2_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                din1_sel = req_bus.req_din1[i*FLT_W +: FLT_W];
                din2_sel = req_bus.req_din2[i*FLT_W +: FLT_W];
            end
        end
    end

    // The divider raises dout_valid LATENCY edges after sampling din_valid; the pipe starts at that
    // sampling edge, so its last stage is registered once more into tag_out to line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_din_valid     <= 1'b0;
            div_din1          <= '0;
            div_din2          <= '0;
            issue_tag         <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            tag_out           <= '0;
            req_bus.rsp_valid <= '0;
            req_bus.rsp_dout  <= '0;
            err               <= 1'b0;
            inflight          <= '0;
        end else begin
            div_din_valid <= accept;
            if (accept) begin
                div_din1  <= din1_sel;
                div_din2  <= din2_sel;
                issue_tag <= grant_idx;
            end

            tag_pipe[0] <= '{valid: div_din_valid, tag: issue_tag};
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            tag_out <= tag_pipe[LATENCY-1];

            req_bus.rsp_valid <= '0;
            if (div_dout_valid) begin
                req_bus.rsp_dout <= div_dout;
            end
            if (rsp_fire) begin
                for (int i = 0; i < NREQ; i++) begin
                    req_bus.rsp_valid[i] <= (tag_out.tag == tag_t'(i));
                end
            end

            if (div_dout_valid != tag_out.valid) begin
                err <= 1'b1;
            end

            if (accept && !rsp_fire) begin
                inflight <= inflight + 1'b1;
            end else if (!accept && rsp_fire) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_float_div_arb.sv
// tb/tb_float_div_arb.sv - directed self-checking bench for float_div_arb with a behavioural divider
module tb_float_div_arb;
    import float_div_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int LAT  = 27;
    localparam int IW   = $clog2(LAT + 2) + 1;
    localparam int RL   = LAT + 2;

    typedef struct {
        int          cyc;
        logic [2:0]  v;
        logic [31:0] d;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_nrst;
    logic [31:0]      div_din1;
    logic [31:0]      div_din2;
    logic             div_din_valid;
    logic [31:0]      div_dout;
    logic             div_dout_valid;
    logic [IW-1:0]    inflight;
    logic             idle;
    logic             err;
    logic             force_dv = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc;
    int got;
    int n0;
    logic [2:0]  exp_g;
    rsp_t        rsp_log [$];
    int          acc_q   [$];
    logic [2:0]  tag_q   [$];
    int          idx_q   [$];
    logic [31:0] quo     [3];

    float_div_arb_if #(.NREQ(NREQ)) bus ();

    float_div_arb #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .req_bus        (bus.slave),
        .div_nrst       (div_nrst),
        .div_din1       (div_din1),
        .div_din2       (div_din2),
        .div_din_valid  (div_din_valid),
        .div_dout       (div_dout),
        .div_dout_valid (div_dout_valid),
        .inflight       (inflight),
        .idle           (idle),
        .err            (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] golden_div(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40400000}: return 32'h40000000;
            {32'h3F800000, 32'h40000000}: return 32'h3F000000;
            {32'h41100000, 32'h40400000}: return 32'h40400000;
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    // Divider: result appears LAT edges after the edge that samples din_valid
    logic        sr_v [0:LAT];
    logic [31:0] sr_d [0:LAT];
    always @(posedge clk) begin
        if (!div_nrst) begin
            for (int i = 0; i <= LAT; i++) begin
                sr_v[i] <= 1'b0;
                sr_d[i] <= '0;
            end
        end else begin
            sr_v[0] <= div_din_valid;
            sr_d[0] <= golden_div(div_din1, div_din2);
            for (int i = 1; i <= LAT; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_d[i] <= sr_d[i-1];
            end
        end
    end
    assign div_dout_valid = sr_v[LAT] | force_dv;
    assign div_dout       = sr_d[LAT];

    always @(negedge clk) begin
        if (|bus.rsp_valid) rsp_log.push_back('{cyc, bus.rsp_valid, bus.rsp_dout});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        quo[0] = 32'h40000000;
        quo[1] = 32'h3F000000;
        quo[2] = 32'h40400000;
        rst = 1'b1;
        en  = 1'b0;
        bus.req_valid = '0;
        bus.req_din1  = {32'h41100000, 32'h3F800000, 32'h40C00000};
        bus.req_din2  = {32'h40400000, 32'h40000000, 32'h40400000};
        repeat (3) @(negedge clk);

        // reset state
        bus.req_valid = 3'b111;
        en = 1'b1;
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_dout", bus.rsp_dout, 0);
        check("rst_din_valid", div_din_valid, 0);
        check("rst_din1", div_din1, 0);
        check("rst_din2", div_din2, 0);
        check("rst_inflight", inflight, 0);
        check("rst_idle", idle, 1);
        check("rst_err", err, 0);
        check("rst_div_nrst", div_nrst, 0);
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // single request from requester 0: 6.0 / 3.0
        bus.req_valid = 3'b001;
        #1;
        check("single_ready", bus.req_ready, 3'b001);
        acc = cyc + 1;
        @(negedge clk);
        bus.req_valid = '0;
        check("single_din_valid", div_din_valid, 1);
        check("single_din1", div_din1, 32'h40C00000);
        check("single_din2", div_din2, 32'h40400000);
        check("single_inflight1", inflight, 1);
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (|bus.rsp_valid) got = 1;
        end
        check("single_latency", cyc - acc, RL);
        check("single_rsp_valid", bus.rsp_valid, 3'b001);
        check("single_rsp_dout", bus.rsp_dout, 32'h40000000);
        check("single_inflight0", inflight, 0);
        check("single_idle", idle, 1);
        @(negedge clk);
        check("single_rsp_clear", bus.rsp_valid, 0);

        // all requesters valid for 30 cycles; pointer sits at 1 after the grant to 0
        rsp_log.delete();
        bus.req_valid = 3'b111;
        exp_g = 3'b010;
        for (int i = 0; i < 30; i++) begin
            #1;
            check("rr_ready", bus.req_ready, exp_g);
            acc_q.push_back(cyc + 1);
            tag_q.push_back(exp_g);
            idx_q.push_back(exp_g[0] ? 0 : (exp_g[1] ? 1 : 2));
            exp_g = {exp_g[1:0], exp_g[2]};
            @(negedge clk);
        end
        bus.req_valid = '0;
        check("rr_inflight_max", inflight, RL);
        repeat (40) @(negedge clk);
        check("rr_rsp_count", rsp_log.size(), 30);
        for (int k = 0; k < 30; k++) begin
            if (k < rsp_log.size()) begin
                check("rr_rsp_latency", rsp_log[k].cyc - acc_q[k], RL);
                check("rr_rsp_valid", rsp_log[k].v, tag_q[k]);
                check("rr_rsp_dout", rsp_log[k].d, quo[idx_q[k]]);
            end
        end
        check("rr_idle", idle, 1);

        // en gating: five grants from pointer 1, then en low
        bus.req_valid = 3'b111;
        exp_g = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("en_ready", bus.req_ready, exp_g);
            acc = cyc + 1;
            exp_g = {exp_g[1:0], exp_g[2]};
            @(negedge clk);
        end
        en = 1'b0;
        #1;
        check("en_low_ready", bus.req_ready, 0);
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (idle) got = 1;
        end
        check("en_idle_delay", cyc - acc, RL);
        en = 1'b1;
        #1;
        check("en_resume0", bus.req_ready, 3'b001);
        @(negedge clk);
        #1;
        check("en_resume1", bus.req_ready, 3'b010);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (40) @(negedge clk);

        // fairness between 1 and 2, then 0 joins after a grant to 2 (pointer at 2 here)
        bus.req_valid = 3'b110;
        #1;
        check("fair_g2a", bus.req_ready, 3'b100);
        @(negedge clk);
        #1;
        check("fair_g1a", bus.req_ready, 3'b010);
        @(negedge clk);
        #1;
        check("fair_g2b", bus.req_ready, 3'b100);
        @(negedge clk);
        bus.req_valid = 3'b111;
        #1;
        check("fair_g0", bus.req_ready, 3'b001);
        @(negedge clk);
        #1;
        check("fair_g1b", bus.req_ready, 3'b010);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (40) @(negedge clk);
        check("fair_idle", idle, 1);
        check("fair_err", err, 0);

        // reset with ten operations in flight
        bus.req_valid = 3'b111;
        repeat (10) @(negedge clk);
        bus.req_valid = '0;
        check("flush_inflight10", inflight, 10);
        rst = 1'b1;
        @(negedge clk);
        check("flush_rsp_valid", bus.rsp_valid, 0);
        check("flush_inflight", inflight, 0);
        check("flush_idle", idle, 1);
        check("flush_din_valid", div_din_valid, 0);
        rst = 1'b0;
        n0 = rsp_log.size();
        repeat (40) @(negedge clk);
        check("flush_no_rsp", rsp_log.size(), n0);
        check("flush_err", err, 0);

        // stray divider valid with an empty pipe
        force_dv = 1'b1;
        @(negedge clk);
        force_dv = 1'b0;
        check("fault_err", err, 1);
        check("fault_rsp_valid", bus.rsp_valid, 0);
        repeat (5) @(negedge clk);
        check("fault_err_sticky", err, 1);
        check("fault_inflight", inflight, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("fault_err_cleared", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
